// File: rtl/cond_logic_mc.sv
// ----------------------------------------------------------------------------
// cond_logic_mc
// Multicycle condition/flag stage for the ARM-subset core.
//
// This block holds the NZCV flag register. It evaluates the instruction
// condition field once per instruction, when the decode strobe fires. It then
// holds that verdict until the instruction retires. The verdict gates the
// PC, register-file and memory write enables. It also gates flag updates.
//
// Optional feature macro: COND_SKIP_CNT_EN
//   defined     -> saturating counter of condition-failed instructions,
//                  cleared by SkipClr
//   undefined   -> no counter flops, SkipCount tied to 0, SkipClr ignored
//
// Parameters
//   SKIP_CNT_W   width of the skipped-instruction counter
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   Cond         instruction condition field Instr[31:28]
//   ALUFlags     {N,Z,C,V} produced by the ALU this cycle
//   FlagW        [1] write N,Z   [0] write C,V
//   PCS          instruction writes the PC
//   NextPC       unconditional fetch-cycle PC increment
//   RegW         register-file write request from the FSM
//   MemW         memory write request from the FSM
//   CondSample   decode strobe: evaluate Cond in this cycle
//   InstrDone    last cycle of the current instruction
//   SkipClr      synchronous clear of SkipCount
//   PCWrite      gated PC write enable
//   RegWrite     gated register write enable
//   MemWrite     gated memory write enable
//   Flags        registered {N,Z,C,V}
//   CondExQ      held verdict for the current instruction
//   Active       a verdict is being held (state ACTIVE)
//   SkipCount    number of instructions whose condition failed
// ----------------------------------------------------------------------------
module cond_logic_mc #(
    parameter int SKIP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    input  logic [1:0]            FlagW,
    input  logic                  PCS,
    input  logic                  NextPC,
    input  logic                  RegW,
    input  logic                  MemW,
    input  logic                  CondSample,
    input  logic                  InstrDone,
    input  logic                  SkipClr,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic [3:0]            Flags,
    output logic                  CondExQ,
    output logic                  Active,
    output logic [SKIP_CNT_W-1:0] SkipCount
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] flags;
    logic       cond_q;
    logic       cond_now;
    logic       cond_eff;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // The condition is evaluated against the registered flags only. An ALU
    // result in the same cycle therefore cannot influence its own verdict.
    // Encoding 4'b1111 is not a valid condition. It evaluates to 0.
    always_comb begin
        cond_now = 1'b0;
        case (Cond)
            4'b0000: cond_now = flag_z;
            4'b0001: cond_now = ~flag_z;
            4'b0010: cond_now = flag_c;
            4'b0011: cond_now = ~flag_c;
            4'b0100: cond_now = flag_n;
            4'b0101: cond_now = ~flag_n;
            4'b0110: cond_now = flag_v;
            4'b0111: cond_now = ~flag_v;
            4'b1000: cond_now = flag_c & ~flag_z;
            4'b1001: cond_now = ~(flag_c & ~flag_z);
            4'b1010: cond_now = (flag_n == flag_v);
            4'b1011: cond_now = (flag_n != flag_v);
            4'b1100: cond_now = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_now = ~(~flag_z & (flag_n == flag_v));
            4'b1110: cond_now = 1'b1;
            default: cond_now = 1'b0;
        endcase
    end

    // The effective verdict comes from the fresh evaluation in the decode
    // cycle. In later cycles it comes from the held verdict. In IDLE it is
    // 0, so stray FSM requests outside an instruction are blocked.
    assign cond_eff = CondSample ? cond_now : ((state == ACTIVE) ? cond_q : 1'b0);

    assign PCWrite  = NextPC | (PCS & cond_eff);
    assign RegWrite = RegW & cond_eff;
    assign MemWrite = MemW & cond_eff;
    assign Flags    = flags;
    assign CondExQ  = cond_q;
    assign Active   = (state == ACTIVE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new decode strobe always wins and keeps us in ACTIVE. This covers
    // back-to-back instructions where the done and decode cycles coincide.
    // InstrDone alone only matters in ACTIVE.
    always_comb begin
        state_next = state;
        if (CondSample) begin
            state_next = ACTIVE;
        end else if ((state == ACTIVE) && InstrDone) begin
            state_next = IDLE;
        end
    end

    // The verdict is captured on every decode strobe. It is otherwise held,
    // including across the return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q <= 1'b0;
        end else if (CondSample) begin
            cond_q <= cond_now;
        end
    end

    // The two flag halves update independently. Each update is gated by the
    // effective verdict, so a failed instruction never alters the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (FlagW[1] && cond_eff) begin
                flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && cond_eff) begin
                flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

`ifdef COND_SKIP_CNT_EN
    logic [SKIP_CNT_W-1:0] skip_cnt;

    // Count failed decode strobes and saturate at all-ones. A clear takes
    // priority over an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_cnt <= '0;
        end else if (SkipClr) begin
            skip_cnt <= '0;
        end else if (CondSample && !cond_now && (skip_cnt != {SKIP_CNT_W{1'b1}})) begin
            skip_cnt <= skip_cnt + 1'b1;
        end
    end

    assign SkipCount = skip_cnt;
`else
    logic unused_skip_clr;

    assign unused_skip_clr = SkipClr;
    assign SkipCount       = '0;
`endif

endmodule

// File: tb/tb_cond_logic_mc.sv
// ----------------------------------------------------------------------------
// tb_cond_logic_mc
// Scoreboard bench for cond_logic_mc. The driver issues one stimulus vector
// per cycle. It advances a behavioural model of the architectural state at
// each clock edge and pushes the expected outputs into a queue. A monitor
// pops the queue on the falling edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_cond_logic_mc;

    localparam int W       = 2;
    localparam int SKIPMAX = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic [3:0]   Cond;
    logic [3:0]   ALUFlags;
    logic [1:0]   FlagW;
    logic         PCS;
    logic         NextPC;
    logic         RegW;
    logic         MemW;
    logic         CondSample;
    logic         InstrDone;
    logic         SkipClr;
    logic         PCWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic [3:0]   Flags;
    logic         CondExQ;
    logic         Active;
    logic [W-1:0] SkipCount;

    typedef struct {
        logic       pcw;
        logic       rw;
        logic       mw;
        logic [3:0] flags;
        logic       condq;
        logic       active;
        int         skip;
    } expect_t;

    expect_t expQueue[$];

    int checks = 0;
    int errors = 0;

    // Architectural state of the reference model
    bit mN, mZ, mC, mV;
    bit mHeld;
    bit mBusy;
    int mSkip;

    cond_logic_mc #(.SKIP_CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .CondSample (CondSample),
        .InstrDone  (InstrDone),
        .SkipClr    (SkipClr),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Flags      (Flags),
        .CondExQ    (CondExQ),
        .Active     (Active),
        .SkipCount  (SkipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The ARM condition rules, expressed as arithmetic on the flag booleans
    function automatic bit modelCond(input logic [3:0] c);
        bit ge;
        ge = (mN == mV);
        case (c)
            4'd0:    return mZ;
            4'd1:    return !mZ;
            4'd2:    return mC;
            4'd3:    return !mC;
            4'd4:    return mN;
            4'd5:    return !mN;
            4'd6:    return mV;
            4'd7:    return !mV;
            4'd8:    return mC && !mZ;
            4'd9:    return !(mC && !mZ);
            4'd10:   return ge;
            4'd11:   return !ge;
            4'd12:   return !mZ && ge;
            4'd13:   return !(!mZ && ge);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit modelEff();
        if (CondSample) return modelCond(Cond);
        return mBusy ? mHeld : 1'b0;
    endfunction

    task automatic modelReset();
        mN = 0; mZ = 0; mC = 0; mV = 0;
        mHeld = 0; mBusy = 0; mSkip = 0;
    endtask

    // One clock edge of the model, using the inputs that were held up to it
    task automatic modelEdge();
        bit now;
        bit eff;
        now = modelCond(Cond);
        eff = modelEff();
        if (FlagW[1] && eff) begin mN = ALUFlags[3]; mZ = ALUFlags[2]; end
        if (FlagW[0] && eff) begin mC = ALUFlags[1]; mV = ALUFlags[0]; end
`ifdef COND_SKIP_CNT_EN
        if (SkipClr) mSkip = 0;
        else if (CondSample && !now && mSkip < SKIPMAX) mSkip = mSkip + 1;
`endif
        if (CondSample) begin
            mHeld = now;
            mBusy = 1;
        end else if (mBusy && InstrDone) begin
            mBusy = 0;
        end
    endtask

    task automatic pushExpected();
        expect_t e;
        bit eff;
        eff      = modelEff();
        e.pcw    = NextPC || (PCS && eff);
        e.rw     = RegW && eff;
        e.mw     = MemW && eff;
        e.flags  = {mN, mZ, mC, mV};
        e.condq  = mHeld;
        e.active = mBusy;
        e.skip   = mSkip;
        expQueue.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic pcs,
                                 input logic npc, input logic rw, input logic mw,
                                 input logic smp, input logic done, input logic clr);
        @(posedge clk);
        if (!reset) modelEdge();
        #1;
        reset      = 1'b0;
        Cond       = c;
        ALUFlags   = alu;
        FlagW      = fw;
        PCS        = pcs;
        NextPC     = npc;
        RegW       = rw;
        MemW       = mw;
        CondSample = smp;
        InstrDone  = done;
        SkipClr    = clr;
        pushExpected();
    endtask

    // Asserts the reset between clock edges. It may land in the middle of an
    // instruction.
    task automatic applyReset(input logic rw);
        @(posedge clk);
        if (!reset) modelEdge();
        #1;
        reset      = 1'b1;
        RegW       = rw;
        MemW       = 1'b0;
        PCS        = 1'b0;
        NextPC     = 1'b0;
        CondSample = 1'b0;
        InstrDone  = 1'b0;
        SkipClr    = 1'b0;
        FlagW      = 2'b00;
        modelReset();
        pushExpected();
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, required);
        end
    endtask

    // Monitor: every cycle the outputs are sampled on the falling edge
    always @(negedge clk) begin
        if (expQueue.size() > 0) begin
            expect_t e;
            e = expQueue.pop_front();
            checkOutput("PCWrite",   int'(PCWrite),   int'(e.pcw));
            checkOutput("RegWrite",  int'(RegWrite),  int'(e.rw));
            checkOutput("MemWrite",  int'(MemWrite),  int'(e.mw));
            checkOutput("Flags",     int'(Flags),     int'(e.flags));
            checkOutput("CondExQ",   int'(CondExQ),   int'(e.condq));
            checkOutput("Active",    int'(Active),    int'(e.active));
            checkOutput("SkipCount", int'(SkipCount), e.skip);
        end
    end

    initial begin
        reset = 1'b1;
        Cond = 4'd0; ALUFlags = 4'd0; FlagW = 2'b00; PCS = 0; NextPC = 0;
        RegW = 0; MemW = 0; CondSample = 0; InstrDone = 0; SkipClr = 0;
        modelReset();

        applyReset(1'b1);
        applyReset(1'b0);

        // Load Flags=0100 using an AL instruction, then run EQ for 3 cycles
        applyStimulus(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(4'h0, 4'b0000, 2'b00, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(4'h0, 4'b0000, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(4'h0, 4'b0000, 2'b00, 0, 0, 1, 1, 0, 1, 0);
        // NE fails, and the writes stay off for the whole instruction
        applyStimulus(4'h1, 4'b0000, 2'b00, 1, 0, 1, 1, 1, 0, 0);
        applyStimulus(4'h1, 4'b0000, 2'b00, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(4'h1, 4'b0000, 2'b00, 1, 0, 1, 1, 0, 1, 0);

        // A partial flag write (N,Z only), then a failed instruction that
        // must not change the flags
        applyStimulus(4'hE, 4'b1011, 2'b10, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'h0, 4'b0111, 2'b11, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'h0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // GT checked against several flag values, then 1111, then NextPC
        applyStimulus(4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'hC, 4'b1000, 2'b11, 0, 0, 1, 0, 1, 0, 0);
        applyStimulus(4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'hC, 4'b0000, 2'b00, 0, 0, 1, 0, 1, 0, 0);
        applyStimulus(4'hE, 4'b1101, 2'b11, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'hC, 4'b0000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
        applyStimulus(4'hF, 4'b0000, 2'b00, 1, 1, 1, 0, 1, 0, 0);
        applyStimulus(4'hF, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 1, 0);

        // Done and a new failing sample in the same cycle while ACTIVE
        applyStimulus(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(4'hF, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(4'h0, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 0);

        // Reset in the middle of a passing instruction
        applyStimulus(4'hE, 4'b1111, 2'b00, 0, 0, 1, 0, 1, 0, 0);
        applyStimulus(4'hE, 4'b1111, 2'b11, 0, 0, 1, 0, 0, 0, 0);
        applyReset(1'b1);

        // Five failed samples saturate the counter, then a clear wins
        for (int i = 0; i < 5; i++)
            applyStimulus(4'hF, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(4'hF, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(4'hF, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset(1'($urandom_range(0, 1)));
            end else begin
                applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", expQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
